// File: rtl/bist_pkg.sv
// Shared types and constants for the full-adder BIST controller.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0]  LFSR_SEED   = 3'b001;
  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned FAIL_CNT_W  = 4;

  // Maximal-length 3-bit LFSR step; never reaches 3'b000 on its own.
  function automatic logic [2:0] lfsr_next(input logic [2:0] p);
    return {p[0] ^ p[2], p[2:1]};
  endfunction

endpackage

// File: rtl/bist_golden.sv
// Reference full-adder producing the expected sum/carry for a pattern {A,B,Cin}.
module bist_golden (
  input  logic [2:0] pattern,
  output logic       exp_sum,
  output logic       exp_carry
);

  logic a, b, cin;

  always_comb begin
    {a, b, cin} = pattern;
    exp_sum     = a ^ b ^ cin;
    exp_carry   = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/bist_ctrl.sv
// BIST sequencer for an external full-adder CUT: drives LFSR patterns plus the
// all-zero vector, compares against bist_golden and accumulates results.
module bist_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = bist_pkg::NUM_VECTORS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  dut_sum,
  input  logic                  dut_carry,
  output logic [2:0]            pattern,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fault,
  output logic [FAIL_CNT_W-1:0] fail_count,
  output logic [2:0]            first_fail,
  output logic                  first_fail_vld
);

  localparam logic [FAIL_CNT_W-1:0] LAST_IDX = FAIL_CNT_W'(NUM_VECTORS - 1);
  localparam logic [FAIL_CNT_W-1:0] FC_MAX   = FAIL_CNT_W'(NUM_VECTORS);

  state_e                state_q, state_d;
  logic [2:0]            lfsr_q, lfsr_d;
  logic [FAIL_CNT_W-1:0] vec_q, vec_d;
  logic [FAIL_CNT_W-1:0] fc_q, fc_d;
  logic [2:0]            ff_q, ff_d;
  logic                  ffv_q, ffv_d;
  logic                  fault_q, fault_d;
  logic                  exp_sum, exp_carry;
  logic                  mismatch;

  bist_golden u_golden (
    .pattern   (pattern),
    .exp_sum   (exp_sum),
    .exp_carry (exp_carry)
  );

  // The final vector of a run is forced to zero since the LFSR cannot produce it.
  always_comb begin
    pattern = LFSR_SEED;
    if (state_q == ST_RUN) begin
      pattern = (vec_q == LAST_IDX) ? 3'b000 : lfsr_q;
    end
  end

  assign mismatch = ({dut_sum, dut_carry} != {exp_sum, exp_carry});

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    vec_d   = vec_q;
    fc_d    = fc_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    fault_d = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          lfsr_d = lfsr_next(lfsr_q);
          vec_d  = vec_q + FAIL_CNT_W'(1);
          if (mismatch) begin
            fault_d = 1'b1;
            if (fc_q != FC_MAX) fc_d = fc_q + FAIL_CNT_W'(1);
            if (!ffv_q) begin
              ff_d  = pattern;
              ffv_d = 1'b1;
            end
          end
          if (vec_q == LAST_IDX) state_d = ST_DONE;
        end
      end
      default: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
          lfsr_d  = LFSR_SEED;
          vec_d   = '0;
          fc_d    = '0;
          ffv_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      vec_q   <= '0;
      fc_q    <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      vec_q   <= vec_d;
      fc_q    <= fc_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      fault_q <= fault_d;
    end
  end

  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign pass           = done && (fc_q == '0);
  assign fault          = fault_q;
  assign fail_count     = fc_q;
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_bist_ctrl.sv
// Randomized bench for bist_ctrl with a behavioural CUT and reference model.
module tb_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic       dut_sum, dut_carry;
  logic [2:0] pattern;
  logic       busy, done, pass, fault, first_fail_vld;
  logic [3:0] fail_count;
  logic [2:0] first_fail;

  int checks = 0;
  int errors = 0;

  // CUT behaviour: 0 good, 1 carry sa1, 2 sum sa0, 3 A inverted, 4 random flips per pattern
  int          mode = 0;
  logic [15:0] mask = '0;

  logic [2:0] seq [8] = '{3'b001, 3'b100, 3'b110, 3'b111, 3'b011, 3'b101, 3'b010, 3'b000};

  bit         m_known = 1'b0;
  bit         m_run   = 1'b0;
  bit         m_done  = 1'b0;
  bit         m_fault = 1'b0;
  bit         m_ffv   = 1'b0;
  int         m_pos   = 0;
  int         m_fc    = 0;
  logic [2:0] m_ff    = '0;

  bist_ctrl #(.NUM_VECTORS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .dut_sum        (dut_sum),
    .dut_carry      (dut_carry),
    .pattern        (pattern),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fault          (fault),
    .fail_count     (fail_count),
    .first_fail     (first_fail),
    .first_fail_vld (first_fail_vld)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] cut_fn(input logic [2:0] v, input int md, input logic [15:0] mk);
    int a, b, c, n;
    logic s, cy;
    logic [1:0] r;
    a = v[2] ? 1 : 0;
    b = v[1] ? 1 : 0;
    c = v[0] ? 1 : 0;
    if (md == 3) a = 1 - a;
    n  = a + b + c;
    s  = (n % 2) == 1;
    cy = n >= 2;
    if (md == 1) cy = 1'b1;
    if (md == 2) s = 1'b0;
    r = {s, cy};
    if (md == 4) r = r ^ mk[int'(v) * 2 +: 2];
    return r;
  endfunction

  always_comb {dut_sum, dut_carry} = cut_fn(pattern, mode, mask);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit a);
    logic [2:0] v;
    bit mm;
    rst = r; start = s; abort = a;
    #1;
    if (m_known) begin
      chk("pattern", 8'(pattern), 8'(m_run ? seq[m_pos] : 3'b001));
      chk("busy_pre", 8'(busy), 8'(m_run));
      chk("done_pre", 8'(done), 8'(m_done));
    end
    @(posedge clk);
    if (r) begin
      m_known = 1'b1; m_run = 1'b0; m_done = 1'b0; m_fault = 1'b0;
      m_fc = 0; m_ff = '0; m_ffv = 1'b0;
    end else if (m_run) begin
      if (a) begin
        m_run = 1'b0; m_fault = 1'b0;
      end else begin
        v  = seq[m_pos];
        mm = cut_fn(v, mode, mask) != cut_fn(v, 0, '0);
        m_fault = mm;
        if (mm) begin
          if (m_fc < 8) m_fc++;
          if (!m_ffv) begin m_ff = v; m_ffv = 1'b1; end
        end
        m_pos++;
        if (m_pos == 8) begin m_run = 1'b0; m_done = 1'b1; end
      end
    end else begin
      m_fault = 1'b0;
      if (a) m_done = 1'b0;
      else if (s) begin
        m_run = 1'b1; m_pos = 0; m_fc = 0; m_ffv = 1'b0; m_done = 1'b0;
      end
    end
    @(negedge clk);
    if (m_known) begin
      chk("busy", 8'(busy), 8'(m_run));
      chk("done", 8'(done), 8'(m_done));
      chk("pass", 8'(pass), 8'(m_done && m_fc == 0));
      chk("fault", 8'(fault), 8'(m_fault));
      chk("fail_count", 8'(fail_count), 8'(m_fc));
      chk("first_fail", 8'(first_fail), 8'(m_ff));
      chk("first_fail_vld", 8'(first_fail_vld), 8'(m_ffv));
    end
  endtask

  task automatic run_full(input int md, input int exp_fc);
    mode = md;
    cycle(0, 1, 0);
    repeat (8) cycle(0, 0, 0);
    chk("dir_done", 8'(done), 8'd1);
    chk("dir_fail_count", 8'(fail_count), 8'(exp_fc));
    chk("dir_pass", 8'(pass), 8'(exp_fc == 0));
    chk("dir_ffv", 8'(first_fail_vld), 8'(exp_fc != 0));
    if (exp_fc != 0) chk("dir_first_fail", 8'(first_fail), 8'h01);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("rst_pattern", 8'(pattern), 8'h01);
    cycle(0, 0, 0);

    run_full(0, 0);
    run_full(1, 4);
    run_full(2, 4);
    run_full(3, 8);

    mode = 1;
    cycle(0, 1, 0);
    repeat (3) cycle(0, 0, 0);
    cycle(0, 0, 1);
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_done", 8'(done), 8'd0);
    chk("abort_fail_count", 8'(fail_count), 8'd2);

    mode = 0;
    cycle(0, 1, 0);
    repeat (8) cycle(0, 1, 0);
    chk("start_ignored_done", 8'(done), 8'd1);
    mode = 3;
    cycle(0, 1, 0);
    repeat (2) cycle(0, 0, 0);
    cycle(1, 1, 0);
    chk("rst_mid_fail_count", 8'(fail_count), 8'd0);
    cycle(0, 1, 1);
    chk("abort_wins_busy", 8'(busy), 8'd0);

    repeat (600) begin
      bit r, s, a;
      if (!m_run && $urandom_range(0, 3) == 0) begin
        mode = int'($urandom_range(0, 4));
        mask = 16'($urandom);
      end
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 14) == 0);
      cycle(r, s, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
